// File: rtl/ascii2int_stream_if.sv
// Handshake bundle for the ASCII-decimal converter: byte stream in, converted result out.
interface ascii2int_stream_if #(
    parameter int OUT_W = 32
);
    logic             valid_i;
    logic [7:0]       data_i;
    logic             last_i;
    logic             ready_o;
    logic             valid_o;
    logic             ready_i;
    logic [OUT_W-1:0] result_o;
    logic             err_o;
    logic [1:0]       err_code_o;

    modport slave (
        input  valid_i, data_i, last_i, ready_i,
        output ready_o, valid_o, result_o, err_o, err_code_o
    );

    modport master (
        output valid_i, data_i, last_i, ready_i,
        input  ready_o, valid_o, result_o, err_o, err_code_o
    );
endinterface

// File: rtl/ascii2int_stream.sv
// Streaming ASCII-decimal to binary converter for FIX numeric fields.
// One field per handoff; errored fields are drained to last_i so the stream stays aligned.
module ascii2int_stream #(
    parameter int OUT_W      = 32,
    parameter int MAX_DIGITS = 10,
    parameter bit SIGNED_EN  = 1'b0
) (
    input logic               clk,
    input logic               rst,
    ascii2int_stream_if.slave bus
);
    localparam int ACC_W = OUT_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 2);

    localparam logic [ACC_W-1:0] LIM_U   = {4'b0, {OUT_W{1'b1}}};
    localparam logic [ACC_W-1:0] LIM_SP  = {5'b0, {(OUT_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] LIM_SN  = LIM_SP + ACC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    typedef enum logic [1:0] {
        E_NONE = 2'd0,
        E_CHAR = 2'd1,
        E_OVF  = 2'd2,
        E_LEN  = 2'd3
    } err_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             neg;
    err_t             err;
    logic [OUT_W-1:0] res_q;
    err_t             code_q;

    logic             take, first, is_digit, is_minus;
    logic [ACC_W-1:0] base_acc, acc_nxt, acc_upd, limit;
    logic [CNT_W-1:0] base_cnt, cnt_nxt, cnt_upd;
    logic             base_neg, neg_nxt;
    err_t             base_err, byte_err, err_nxt, final_err;
    logic [OUT_W-1:0] signed_res;

    assign take     = bus.valid_i & bus.ready_o;
    assign first    = (state == IDLE);
    assign is_digit = (bus.data_i >= 8'h30) && (bus.data_i <= 8'h39);
    assign is_minus = SIGNED_EN && first && (bus.data_i == 8'h2D);

    // A new field starts from zeroed context, so nothing needs clearing at handoff.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        base_acc = first ? '0     : acc;
        base_cnt = first ? '0     : cnt;
        base_neg = first ? 1'b0   : neg;
        base_err = first ? E_NONE : err;

        neg_nxt  = base_neg | is_minus;
        cnt_nxt  = base_cnt + CNT_W'(is_digit);
        acc_nxt  = base_acc * ACC_W'(10) + ACC_W'(bus.data_i[3:0]);
        limit    = !SIGNED_EN ? LIM_U : (neg_nxt ? LIM_SN : LIM_SP);

        // Priority on one byte: bad char > too long > overflow.
        byte_err = E_NONE;
        if (is_minus)                byte_err = E_NONE;
        else if (!is_digit)          byte_err = E_CHAR;
        else if (cnt_nxt > CNT_MAX)  byte_err = E_LEN;
        else if (acc_nxt > limit)    byte_err = E_OVF;

        err_nxt   = (base_err != E_NONE) ? base_err : byte_err;
        acc_upd   = (err_nxt == E_NONE && is_digit) ? acc_nxt : base_acc;
        cnt_upd   = (err_nxt == E_NONE) ? cnt_nxt : base_cnt;
        final_err = (err_nxt == E_NONE && cnt_upd == '0) ? E_LEN : err_nxt;

        signed_res = neg_nxt ? -acc_upd[OUT_W-1:0] : acc_upd[OUT_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            err    <= E_NONE;
            res_q  <= '0;
            code_q <= E_NONE;
        end else if (take) begin
            acc <= acc_upd;
            cnt <= cnt_upd;
            neg <= neg_nxt;
            err <= err_nxt;
            if (bus.last_i) begin
                code_q <= final_err;
                res_q  <= (final_err == E_NONE) ? signed_res : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: if (take) state_nxt = bus.last_i ? DONE : ACCUM;
            DONE:        if (bus.ready_i) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ready_o = 1'b0;
        bus.valid_o = 1'b0;
        case (state)
            IDLE, ACCUM: bus.ready_o = 1'b1;
            DONE:        bus.valid_o = 1'b1;
            default:     bus.ready_o = 1'b0;
        endcase
    end

    assign bus.result_o   = res_q;
    assign bus.err_code_o = code_q;
    assign bus.err_o      = (code_q != E_NONE);
endmodule

// File: tb/tb_ascii2int_stream.sv
// Bench for ascii2int_stream: three configurations run in lockstep on one byte stream,
// each checked against a string-level reference model on every cycle a result is presented.
module tb_ascii2int_stream;
    typedef byte unsigned bq_t[$];
    typedef struct packed {
        logic [63:0] ra, rb, rc;
        logic [1:0]  ca, cb, cc;
    } exp_t;

    logic       clk, rst;
    logic       valid_i, last_i, ready_i;
    logic [7:0] data_i;
    bit         rand_ready;
    int         n_cmp = 0, n_fail = 0;
    exp_t       exp_q[$];
    exp_t       e_cur;

    ascii2int_stream_if #(.OUT_W(32)) ia ();
    ascii2int_stream_if #(.OUT_W(32)) ib ();
    ascii2int_stream_if #(.OUT_W(8))  ic ();

    ascii2int_stream #(.OUT_W(32), .MAX_DIGITS(10), .SIGNED_EN(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    ascii2int_stream #(.OUT_W(32), .MAX_DIGITS(10), .SIGNED_EN(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    ascii2int_stream #(.OUT_W(8),  .MAX_DIGITS(3),  .SIGNED_EN(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

    assign ia.valid_i = valid_i; assign ia.data_i = data_i; assign ia.last_i = last_i; assign ia.ready_i = ready_i;
    assign ib.valid_i = valid_i; assign ib.data_i = data_i; assign ib.last_i = last_i; assign ib.ready_i = ready_i;
    assign ic.valid_i = valid_i; assign ic.data_i = data_i; assign ic.last_i = last_i; assign ic.ready_i = ready_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference: walk the field as text, first error wins, value kept wide so nothing wraps.
    function automatic logic [65:0] model(input bq_t f, input int ow, input int md, input bit se);
        logic [71:0] acc, nxt, lim, val;
        logic [1:0]  code;
        logic [63:0] res;
        int          cnt;
        bit          neg;
        acc = '0; cnt = 0; neg = 1'b0; code = 2'd0;
        foreach (f[i]) begin
            if (code != 2'd0) continue;
            if (i == 0 && se && f[i] == 8'h2D) neg = 1'b1;
            else if (f[i] < 8'h30 || f[i] > 8'h39) code = 2'd1;
            else begin
                cnt++;
                nxt = acc * 72'd10 + 72'(f[i] - 8'h30);
                lim = se ? ((72'd1 << (ow - 1)) - (neg ? 72'd0 : 72'd1)) : ((72'd1 << ow) - 72'd1);
                if (cnt > md)       code = 2'd3;
                else if (nxt > lim) code = 2'd2;
                else                acc = nxt;
            end
        end
        if (code == 2'd0 && cnt == 0) code = 2'd3;
        val = (code != 2'd0) ? 72'd0 : (neg ? (72'd0 - acc) : acc);
        val = val & ((72'd1 << ow) - 72'd1);
        res = val[63:0];
        return {code, res};
    endfunction

    function automatic logic [65:0] model_cfg(input bq_t f, input int cfg);
        case (cfg)
            0:       return model(f, 32, 10, 1'b0);
            1:       return model(f, 32, 10, 1'b1);
            default: return model(f, 8, 3, 1'b1);
        endcase
    endfunction

    function automatic exp_t expect_of(input bq_t f);
        exp_t        e;
        logic [65:0] m;
        m = model_cfg(f, 0); e.ra = m[63:0]; e.ca = m[65:64];
        m = model_cfg(f, 1); e.rb = m[63:0]; e.cb = m[65:64];
        m = model_cfg(f, 2); e.rc = m[63:0]; e.cc = m[65:64];
        return e;
    endfunction

    task automatic pin(input string s, input int cfg, input logic [63:0] r, input logic [1:0] c);
        logic [65:0] m;
        m = model_cfg(str2q(s), cfg);
        check({"model_res ", s}, m[63:0], r);
        check({"model_code ", s}, {62'd0, m[65:64]}, {62'd0, c});
    endtask

    function automatic bq_t rand_field();
        bq_t         q;
        string       pre;
        int          mode, len, r;
        byte unsigned b;
        mode = $urandom_range(0, 9);
        case (mode)
            0:       pre = "429496729";
            1:       pre = "-214748364";
            2:       pre = "214748364";
            3:       pre = "12";
            4:       pre = "-12";
            default: pre = "";
        endcase
        q = str2q(pre);
        if (mode <= 4) len = $urandom_range(1, 2);
        else len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 22) : $urandom_range(1, 11);
        for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 99);
            if (q.size() == 0 && r < 15) q.push_back(8'h2D);
            else if (r < 4) begin
                b = 8'($urandom_range(0, 255));
                if (b >= 8'h30 && b <= 8'h39) b = 8'h78;
                q.push_back(b);
            end else q.push_back(8'h30 + 8'($urandom_range(0, 9)));
        end
        return q;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the edge that accepted the byte.
    task automatic send_byte(input byte unsigned b, input bit l);
        int n;
        bit took;
        n = 0; took = 1'b0;
        valid_i = 1'b1; data_i = b; last_i = l;
        while (!took && n < 200) begin
            @(negedge clk);
            took = ia.ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        check("byte_accepted", {63'd0, took}, 64'd1);
        valid_i = 1'b0;
        last_i  = 1'($urandom_range(0, 1));
        data_i  = 8'($urandom_range(0, 255));
    endtask

    task automatic send_field(input bq_t f, input bit gaps);
        exp_q.push_back(expect_of(f));
        foreach (f[i]) begin
            send_byte(f[i], i == f.size() - 1);
            if (gaps && i != f.size() - 1)
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        @(negedge clk);
        check("valid_latency", {61'd0, ia.valid_o, ib.valid_o, ic.valid_o}, 64'd7);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        #1;
    endtask

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Every cycle a result is held, all three DUTs must show the model's value for the oldest field.
    always @(negedge clk) begin
        if (!rst && ia.valid_o) begin
            check("result_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e_cur = exp_q[0];
                check("a_ready_in_done", {63'd0, ia.ready_o}, 64'd0);
                check("bc_valid", {62'd0, ib.valid_o, ic.valid_o}, 64'd3);
                check("a_result", {32'd0, ia.result_o}, e_cur.ra);
                check("a_code", {62'd0, ia.err_code_o}, {62'd0, e_cur.ca});
                check("a_err", {63'd0, ia.err_o}, {63'd0, e_cur.ca != 2'd0});
                check("b_result", {32'd0, ib.result_o}, e_cur.rb);
                check("b_code", {62'd0, ib.err_code_o}, {62'd0, e_cur.cb});
                check("b_err", {63'd0, ib.err_o}, {63'd0, e_cur.cb != 2'd0});
                check("c_result", {56'd0, ic.result_o}, e_cur.rc);
                check("c_code", {62'd0, ic.err_code_o}, {62'd0, e_cur.cc});
                if (ready_i) void'(exp_q.pop_front());
            end
        end
    end

    string dl[$] = '{"-45", "4294967295", "4294967296", "-2147483648", "2147483648", "12a4",
                     "0012", "-", "-0", "-128", "128", "999a", "1000", "00000000000000000000001"};

    initial begin
        rst = 1'b1; valid_i = 1'b0; data_i = 8'h00; last_i = 1'b0; ready_i = 1'b0; rand_ready = 1'b0;

        pin("123", 0, 64'd123, 2'd0);
        pin("-45", 1, 64'hFFFF_FFD3, 2'd0);
        pin("-45", 0, 64'd0, 2'd1);
        pin("4294967295", 0, 64'hFFFF_FFFF, 2'd0);
        pin("4294967296", 0, 64'd0, 2'd2);
        pin("-2147483648", 1, 64'h8000_0000, 2'd0);
        pin("2147483648", 1, 64'd0, 2'd2);
        pin("12a4", 0, 64'd0, 2'd1);
        pin("0012", 2, 64'd0, 2'd3);
        pin("-", 1, 64'd0, 2'd3);
        pin("-0", 1, 64'd0, 2'd0);
        pin("-128", 2, 64'h80, 2'd0);
        pin("999a", 2, 64'd0, 2'd2);
        pin("1000", 2, 64'd0, 2'd3);

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {61'd0, ia.valid_o, ib.valid_o, ic.valid_o}, 64'd0);
        check("rst_ready", {63'd0, ia.ready_o}, 64'd1);
        check("rst_result", {32'd0, ia.result_o}, 64'd0);
        check("rst_err", {61'd0, ia.err_o, ia.err_code_o}, 64'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic conversion, latency and the one-cycle bubble.
        ready_i = 1'b1;
        exp_q.push_back(expect_of(str2q("123")));
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b1);
        @(negedge clk);
        check("t1_valid", {63'd0, ia.valid_o}, 64'd1);
        check("t1_result", {32'd0, ia.result_o}, 64'd123);
        check("t1_err", {63'd0, ia.err_o}, 64'd0);
        check("t1_ready_low", {63'd0, ia.ready_o}, 64'd0);
        @(negedge clk);
        check("t1_ready_back", {63'd0, ia.ready_o}, 64'd1);
        check("t1_valid_gone", {63'd0, ia.valid_o}, 64'd0);
        @(posedge clk);
        #1;

        foreach (dl[i]) send_field(str2q(dl[i]), 1'b0);

        // Backpressure with the next field's first byte waiting.
        ready_i = 1'b0;
        send_field(str2q("7"), 1'b0);
        valid_i = 1'b1; data_i = 8'h38; last_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", {63'd0, ia.ready_o}, 64'd0);
            check("bp_valid", {63'd0, ia.valid_o}, 64'd1);
            check("bp_result", {32'd0, ia.result_o}, 64'd7);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        send_field(str2q("8"), 1'b0);

        // Asynchronous reset mid-field.
        drain();
        send_byte(8'h39, 1'b0);
        send_byte(8'h38, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {63'd0, ia.valid_o}, 64'd0);
        check("arst_ready", {63'd0, ia.ready_o}, 64'd1);
        #2 rst = 1'b0;
        @(negedge clk);
        check("arst_rel_ready", {61'd0, ia.ready_o, ib.ready_o, ic.ready_o}, 64'd7);
        check("arst_rel_valid", {63'd0, ia.valid_o}, 64'd0);
        @(posedge clk);
        #1;
        pin("5", 0, 64'd5, 2'd0);
        send_field(str2q("5"), 1'b0);

        rand_ready = 1'b1;
        repeat (300) send_field(rand_field(), 1'b1);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ascii2int_stream.md
Name: ascii2int_stream

Overview:
Streaming ASCII-decimal to binary converter for FIX numeric tag values (lengths, quantities, sequence numbers).
- Accepts a variable-length field of 1..MAX_DIGITS digit bytes, optionally with a leading '-'.
- Field end is marked by last_i on the final byte.
- Produces a binary result with valid/ready handshaking and error reporting.
- Sits between the field splitter and the tag-value decoders; supersedes the fixed three-digit converter.

Parameters:
OUT_W, 32, result width in bits (8..64)
MAX_DIGITS, 10, maximum digit characters accepted per field (1..19)
SIGNED_EN, 0, 1 = leading '-' accepted and result is two's complement; 0 = '-' is an illegal character

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
valid_i  in  1  input byte valid
data_i  in  8  ASCII byte
last_i  in  1  final byte of field; qualified by valid_i
ready_o  out  1  block can accept a byte this cycle
valid_o  out  1  result available
ready_i  in  1  downstream accepts result
result_o  out  OUT_W  converted value; 0 when err_o = 1
err_o  out  1  field had an error
err_code_o  out  2  0 = none, 1 = bad char, 2 = overflow, 3 = empty/too long

Behaviour:
- Reset (asynchronous, any state, including mid-field):
  - state = IDLE.
  - accumulator, digit count, neg flag, error registers, valid_o, result_o and err_o/err_code_o all cleared to 0.
  - ready_o = 1 on the first cycle after reset release.
- Byte acceptance: a byte is accepted when valid_i & ready_o.
- States:
  - IDLE: waiting for the first byte of a field. ready_o = 1.
  - ACCUM: mid-field. ready_o = 1.
  - DONE: holding result. ready_o = 0, valid_o = 1.
- IDLE, accepted byte:
  - '0'..'9': acc = digit, cnt = 1.
  - '-' with SIGNED_EN = 1: neg = 1, cnt = 0.
  - any other byte: latch error code 1.
  - Next state is DONE if last_i = 1, else ACCUM.
- ACCUM, accepted byte:
  - Digit: acc = acc*10 + digit, cnt += 1.
  - '-' in any non-first position, or any non-digit byte: code 1.
  - last_i = 1 -> DONE.
- Arithmetic:
  - acc is OUT_W+4 bits.
  - Overflow, code 2, when acc exceeds the limit for the current sign:
    - unsigned: 2^OUT_W - 1
    - signed positive: 2^(OUT_W-1) - 1
    - signed negative: 2^(OUT_W-1)
  - Once any error is latched, acc stops updating, to avoid wrap.
- cnt > MAX_DIGITS -> code 3. A field ending with cnt = 0 (e.g. "-" alone) -> code 3.
- Error priority: the first error detected in the field is latched and is sticky until the field is handed off. Later errors do not change the code.
  - Simultaneous errors on one byte: bad char (1) > too long (3) > overflow (2).
- Remaining bytes of an errored field are still consumed up to last_i. No early exit, so the stream stays aligned.
- DONE outputs:
  - result_o = neg ? -acc[OUT_W-1:0] : acc[OUT_W-1:0], or 0 on error.
  - valid_o rises the cycle after the last byte is accepted (latency 1).
- Handoff: valid_o & ready_i -> IDLE in the same edge. ready_o = 1 the next cycle, so there is one bubble per field.
- valid_i while in DONE is ignored (not accepted). Outputs hold stable until ready_i.
- Leading zeros are legal and count toward MAX_DIGITS. "-0" gives result 0 with no error.
- last_i without valid_i is ignored.

Test Plan:
1. Default params, bytes "1","2","3" with last on "3", ready_i=1 -> valid_o one cycle after "3"; result_o=123, err_o=0; ready_o=1 two cycles after "3".
2. SIGNED_EN=1, "-45" -> result_o=32'hFFFFFFD3, err_code_o=0. SIGNED_EN=0, same field -> err_code_o=1, result_o=0.
3. OUT_W=32 unsigned, "4294967295" -> 32'hFFFFFFFF, no error. "4294967296" -> err_code_o=2. SIGNED_EN=1, "-2147483648" -> 32'h80000000, no error; "2147483648" -> code 2.
4. "12a4" -> all four bytes consumed, err_code_o=1, result_o=0. MAX_DIGITS=3, "0012" -> code 3. Lone "-" with last (SIGNED_EN=1) -> code 3.
5. Backpressure: ready_i held 0 for 3 cycles after valid_o while valid_i=1 with the next field's first byte -> ready_o=0, result_o/valid_o stable, byte not consumed. On ready_i=1 the next field converts correctly.
6. Assert rst asynchronously (between clock edges) after "98" of "987" -> valid_o=0, ready_o=1 immediately after release. Following field "5"+last -> result_o=5.
